// File: rtl/fetch_decode_unit_if.sv
// fetch_decode_unit_if: control/imem-write/decode bundle of the RV32I front end; ILLEGAL_INSN_EN adds illegal
interface fetch_decode_unit_if #(parameter int ADDR_W = 8);
  logic stall;
  logic redirect;
  logic [31:0] redirect_pc;
  logic imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [31:0] imm;
  logic [5:0] name;
  logic rd_we;
  logic is_branch;
`ifdef ILLEGAL_INSN_EN
  logic illegal;
`endif
  modport master (
`ifdef ILLEGAL_INSN_EN
    input illegal,
`endif
    output stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
    input pc, instr, opcode, rd, funct3, rs1, rs2, imm, name, rd_we, is_branch
  );
  modport slave (
`ifdef ILLEGAL_INSN_EN
    output illegal,
`endif
    input stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
    output pc, instr, opcode, rd, funct3, rs1, rs2, imm, name, rd_we, is_branch
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: RV32I PC, writable imem and combinational decode; ILLEGAL_INSN_EN adds the illegal flag
module fetch_decode_unit #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic nreset,
  fetch_decode_unit_if.slave bus
);
  localparam logic [31:0] NOP = 32'h00000013;
  logic [31:0] mem [IMEM_DEPTH] = '{default: NOP};
  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0] op;
  logic [2:0] f3;
  logic aluc;
  logic [5:0] dec;
  logic [5:0] name;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) pc <= '0;
    else pc <= bus.redirect ? bus.redirect_pc : bus.stall ? pc : pc + 32'd1;
  always_ff @(posedge clk)
    if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
  assign instr = pc < 32'(IMEM_DEPTH) ? mem[pc[ADDR_W-1:0]] : NOP;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign aluc = instr[30];
  always_comb begin
    dec = '0;
    case (op)
      7'b0110111: dec = 6'd1;
      7'b0010111: dec = 6'd2;
      7'b1101111: dec = 6'd3;
      7'b1100111: dec = f3 == 3'd0 ? 6'd4 : 6'd0;
      7'b1100011: dec = f3 == 3'd0 ? 6'd5 : f3 == 3'd1 ? 6'd6 : f3[2] ? 6'(f3) + 6'd3 : 6'd0;
      7'b0000011: dec = f3 < 3'd3 ? 6'(f3) + 6'd11 : (f3 == 3'd4 || f3 == 3'd5) ? 6'(f3) + 6'd10 : 6'd0;
      7'b0100011: dec = f3 < 3'd3 ? 6'(f3) + 6'd16 : 6'd0;
      7'b0010011:
        case (f3)
          3'd0: dec = 6'd19;
          3'd1: dec = aluc ? 6'd0 : 6'd25;
          3'd2: dec = 6'd20;
          3'd3: dec = 6'd21;
          3'd4: dec = 6'd22;
          3'd5: dec = aluc ? 6'd27 : 6'd26;
          3'd6: dec = 6'd23;
          default: dec = 6'd24;
        endcase
      7'b0110011:
        case ({aluc, f3})
          4'b0000: dec = 6'd28;
          4'b1000: dec = 6'd29;
          4'b0001: dec = 6'd30;
          4'b0010: dec = 6'd31;
          4'b0011: dec = 6'd32;
          4'b0100: dec = 6'd33;
          4'b0101: dec = 6'd34;
          4'b1101: dec = 6'd35;
          4'b0110: dec = 6'd36;
          4'b0111: dec = 6'd37;
          default: dec = 6'd0;
        endcase
      7'b0001111: dec = f3 == 3'd0 ? 6'd38 : 6'd0;
      7'b1110011: dec = (f3 == 3'd0 && !aluc) ? (instr[20] ? 6'd40 : 6'd39) : 6'd0;
      default: dec = '0;
    endcase
  end
  // the canonical NOP would otherwise decode as ADDI x0,x0,0
  assign name = instr == NOP ? 6'd0 : dec;
  assign bus.pc = pc;
  assign bus.instr = instr;
  assign bus.opcode = op;
  assign bus.rd = instr[11:7];
  assign bus.funct3 = f3;
  assign bus.rs1 = instr[19:15];
  assign bus.rs2 = instr[24:20];
  assign bus.name = name;
  assign bus.imm = name == 6'd0 ? 32'd0 :
                   (name == 6'd1 || name == 6'd2) ? {instr[31:12], 12'b0} :
                   name == 6'd3 ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                   name inside {[6'd5:6'd10]} ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                   name inside {[6'd16:6'd18]} ? {{21{instr[31]}}, instr[30:25], instr[11:7]} :
                   {{21{instr[31]}}, instr[30:20]};
  assign bus.rd_we = name inside {[6'd1:6'd3], [6'd11:6'd15], [6'd19:6'd37]};
  assign bus.is_branch = name inside {[6'd5:6'd10]};
`ifdef ILLEGAL_INSN_EN
  assign bus.illegal = dec == 6'd0 && instr != NOP;
`endif
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: table-driven decode vectors plus PC redirect/stall/reset/write sequences
module tb_fetch_decode_unit;
  logic clk = 1'b0;
  logic nreset;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  fetch_decode_unit_if #(.ADDR_W(8)) bus ();
  fetch_decode_unit #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (.clk(clk), .nreset(nreset), .bus(bus.slave));
  typedef struct {
    logic [31:0] w;
    logic [5:0] name;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    logic we, br, ill;
  } vec_t;
  vec_t v [16];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    v[0]  = '{32'h00500093, 6'd19, 5'd1,  5'd0,  5'd5,  32'h00000005, 1'b1, 1'b0, 1'b0};
    v[1]  = '{32'h40208133, 6'd29, 5'd2,  5'd1,  5'd2,  32'h00000402, 1'b1, 1'b0, 1'b0};
    v[2]  = '{32'h4040D193, 6'd27, 5'd3,  5'd1,  5'd4,  32'h00000404, 1'b1, 1'b0, 1'b0};
    v[3]  = '{32'hFE000EE3, 6'd5,  5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0, 1'b1, 1'b0};
    v[4]  = '{32'h00100073, 6'd40, 5'd0,  5'd0,  5'd1,  32'h00000001, 1'b0, 1'b0, 1'b0};
    v[5]  = '{32'h00000073, 6'd39, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
    v[6]  = '{32'hFFFFFFFF, 6'd0,  5'd31, 5'd31, 5'd31, 32'h00000000, 1'b0, 1'b0, 1'b1};
    v[7]  = '{32'h00000013, 6'd0,  5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
    v[8]  = '{32'h12345537, 6'd1,  5'd10, 5'd8,  5'd3,  32'h12345000, 1'b1, 1'b0, 1'b0};
    v[9]  = '{32'h008000EF, 6'd3,  5'd1,  5'd0,  5'd8,  32'h00000008, 1'b1, 1'b0, 1'b0};
    v[10] = '{32'h0020A423, 6'd18, 5'd8,  5'd1,  5'd2,  32'h00000008, 1'b0, 1'b0, 1'b0};
    v[11] = '{32'h4020D1B3, 6'd35, 5'd3,  5'd1,  5'd2,  32'h00000402, 1'b1, 1'b0, 1'b0};
    v[12] = '{32'h40009093, 6'd0,  5'd1,  5'd1,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
    v[13] = '{32'h0000000F, 6'd38, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
    v[14] = '{32'hFFF34283, 6'd14, 5'd5,  5'd6,  5'd31, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    v[15] = '{32'h80000397, 6'd2,  5'd7,  5'd0,  5'd0,  32'h80000000, 1'b1, 1'b0, 1'b0};
    nreset = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_we = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    #2;
    chk("reset_pc", bus.pc, 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.imem_we = 1'b1;
      bus.imem_waddr = 8'(i);
      bus.imem_wdata = v[i].w;
      tick();
    end
    bus.imem_we = 1'b0;
    chk("pc_held_in_reset", bus.pc, 32'd0);
    nreset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d_pc", i), bus.pc, 32'(i));
      chk($sformatf("v%0d_instr", i), bus.instr, v[i].w);
      chk($sformatf("v%0d_opcode", i), 32'(bus.opcode), 32'(v[i].w[6:0]));
      chk($sformatf("v%0d_funct3", i), 32'(bus.funct3), 32'(v[i].w[14:12]));
      chk($sformatf("v%0d_name", i), 32'(bus.name), 32'(v[i].name));
      chk($sformatf("v%0d_rd", i), 32'(bus.rd), 32'(v[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(bus.rs1), 32'(v[i].rs1));
      chk($sformatf("v%0d_rs2", i), 32'(bus.rs2), 32'(v[i].rs2));
      chk($sformatf("v%0d_imm", i), bus.imm, v[i].imm);
      chk($sformatf("v%0d_rd_we", i), 32'(bus.rd_we), 32'(v[i].we));
      chk($sformatf("v%0d_is_branch", i), 32'(bus.is_branch), 32'(v[i].br));
`ifdef ILLEGAL_INSN_EN
      chk($sformatf("v%0d_illegal", i), 32'(bus.illegal), 32'(v[i].ill));
`endif
      tick();
    end
    chk("pc_after_table", bus.pc, 32'd16);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd3;
    tick();
    chk("redirect_pc3", bus.pc, 32'd3);
    chk("redirect_name_beq", 32'(bus.name), 32'd5);
    bus.stall = 1'b1;
    bus.redirect_pc = 32'd7;
    tick();
    chk("redirect_over_stall", bus.pc, 32'd7);
    bus.redirect = 1'b0;
    tick();
    chk("stall_hold", bus.pc, 32'd7);
    bus.stall = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd300;
    tick();
    chk("oob_pc", bus.pc, 32'd300);
    chk("oob_instr", bus.instr, 32'h00000013);
    chk("oob_name", 32'(bus.name), 32'd0);
    chk("oob_rd_we", 32'(bus.rd_we), 32'd0);
`ifdef ILLEGAL_INSN_EN
    chk("oob_illegal", 32'(bus.illegal), 32'd0);
`endif
    bus.redirect_pc = 32'hFFFFFFFF;
    tick();
    bus.redirect = 1'b0;
    chk("pc_max", bus.pc, 32'hFFFFFFFF);
    tick();
    chk("pc_wrap", bus.pc, 32'd0);
    chk("wrap_instr", bus.instr, 32'h00500093);
    bus.stall = 1'b1;
    bus.imem_we = 1'b1;
    bus.imem_waddr = 8'd0;
    bus.imem_wdata = 32'h00100073;
    #1;
    chk("write_no_bypass", bus.instr, 32'h00500093);
    tick();
    bus.imem_we = 1'b0;
    chk("write_after_edge", bus.instr, 32'h00100073);
    chk("write_after_edge_name", 32'(bus.name), 32'd40);
    bus.stall = 1'b0;
    tick();
    tick();
    chk("pc_before_async_reset", bus.pc, 32'd2);
    #2;
    nreset = 1'b0;
    #1;
    chk("async_reset_pc", bus.pc, 32'd0);
    #2;
    nreset = 1'b1;
    #1;
    chk("release_pc0", bus.pc, 32'd0);
    chk("retained_mem0", bus.instr, 32'h00100073);
    tick();
    chk("release_pc1", bus.pc, 32'd1);
    chk("retained_mem1", bus.instr, 32'h40208133);
    tick();
    chk("release_pc2", bus.pc, 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
